// File: rtl/zacore_memory.sv
// rtl/zacore_memory.sv - memory pipeline stage: load/store bus access, load alignment, writeback register
module zacore_memory #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_execute_memory_if_valid,
    input  logic [XLEN-1:0]   i_execute_memory_if_alu_result,
    input  logic [XLEN-1:0]   i_execute_memory_if_store_data,
    input  logic [1:0]        i_execute_memory_if_mem_op,
    input  logic [1:0]        i_execute_memory_if_size,
    input  logic              i_execute_memory_if_load_signed,
    input  logic [4:0]        i_execute_memory_if_rd_idx,
    input  logic              i_execute_memory_if_rd_we,
    output logic              o_memory_writeback_if_valid,
    output logic [4:0]        o_memory_writeback_if_rd_idx,
    output logic              o_memory_writeback_if_rd_we,
    output logic [XLEN-1:0]   o_memory_writeback_if_rd_data,
    output logic              o_memory_writeback_if_misaligned,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [XLEN-1:0]   o_dmem_wdata,
    output logic [3:0]        o_dmem_wstrb,
    input  logic              i_dmem_ack,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic              o_stall,
    input  logic              i_stall,
    input  logic              i_invalidate
);

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] SZ_B     = 2'd0;
    localparam logic [1:0] SZ_H     = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DRAIN
    } state_t;

    state_t state_q, state_d;

    // Captured request; held stable for the whole bus transaction.
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        wstrb_q;
    logic [4:0]        rd_idx_q;
    logic              rd_we_q;

    // Holds a bus result that completed while downstream was stalled.
    logic              buf_valid_q;
    logic [4:0]        buf_rd_idx_q;
    logic              buf_rd_we_q;
    logic [XLEN-1:0]   buf_rd_data_q;

    logic [1:0]        in_off;
    logic              in_is_mem;
    logic              in_misaligned;
    logic              accept;
    logic              issue;
    logic              ack_take;
    logic [3:0]        in_wstrb;
    logic [XLEN-1:0]   in_wdata;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_data;

    assign in_off    = i_execute_memory_if_alu_result[1:0];
    assign in_is_mem = (i_execute_memory_if_mem_op == OP_LOAD) ||
                       (i_execute_memory_if_mem_op == OP_STORE);

    // Halfwords need an even address, words a multiple of four.
    always_comb begin
        in_misaligned = 1'b0;
        if (in_is_mem) begin
            if (i_execute_memory_if_size == SZ_H) begin
                in_misaligned = in_off[0];
            end else if (i_execute_memory_if_size != SZ_B) begin
                in_misaligned = (in_off != 2'b00);
            end
        end
    end

    // A pending buffered result must reach the output before anything new enters.
    assign accept   = (state_q == ST_IDLE) && i_execute_memory_if_valid && !i_stall &&
                      !i_invalidate && !buf_valid_q;
    assign issue    = accept && in_is_mem && !in_misaligned;
    assign ack_take = (state_q == ST_BUS) && i_dmem_ack && !i_invalidate;

    // Byte-lane replication and enables for stores; loads drive no strobes.
    always_comb begin
        in_wstrb = 4'b1111;
        in_wdata = i_execute_memory_if_store_data;
        case (i_execute_memory_if_size)
            SZ_B: begin
                in_wstrb = 4'b0001 << in_off;
                in_wdata = {4{i_execute_memory_if_store_data[7:0]}};
            end
            SZ_H: begin
                in_wstrb = 4'b0011 << in_off;
                in_wdata = {2{i_execute_memory_if_store_data[15:0]}};
            end
            default: begin
                in_wstrb = 4'b1111;
                in_wdata = i_execute_memory_if_store_data;
            end
        endcase
        if (i_execute_memory_if_mem_op != OP_STORE) begin
            in_wstrb = 4'b0000;
        end
    end

    // Select the addressed byte/half of the returned word and extend it.
    assign shifted = i_dmem_rdata >> {off_q, 3'b000};
    always_comb begin
        load_data = shifted;
        case (size_q)
            SZ_B:    load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
        if (we_q) begin
            load_data = '0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a started transaction always runs to its ack, even when flushed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (i_dmem_ack) begin
                    state_d = ST_IDLE;
                end else if (i_invalidate) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_dmem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request fields when a bus access is issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q   <= '0;
            off_q    <= 2'b00;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= 4'b0000;
            rd_idx_q <= 5'd0;
            rd_we_q  <= 1'b0;
        end else if (issue) begin
            addr_q   <= {i_execute_memory_if_alu_result[ADDR_W-1:2], 2'b00};
            off_q    <= in_off;
            size_q   <= i_execute_memory_if_size;
            signed_q <= i_execute_memory_if_load_signed;
            we_q     <= (i_execute_memory_if_mem_op == OP_STORE);
            wdata_q  <= in_wdata;
            wstrb_q  <= in_wstrb;
            rd_idx_q <= i_execute_memory_if_rd_idx;
            rd_we_q  <= i_execute_memory_if_rd_we;
        end
    end

    // Output register and stall buffer: flush wins, then freeze, then buffered, bus, direct results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_memory_writeback_if_valid      <= 1'b0;
            o_memory_writeback_if_rd_idx     <= 5'd0;
            o_memory_writeback_if_rd_we      <= 1'b0;
            o_memory_writeback_if_rd_data    <= '0;
            o_memory_writeback_if_misaligned <= 1'b0;
            buf_valid_q                      <= 1'b0;
            buf_rd_idx_q                     <= 5'd0;
            buf_rd_we_q                      <= 1'b0;
            buf_rd_data_q                    <= '0;
        end else if (i_invalidate) begin
            o_memory_writeback_if_valid <= 1'b0;
            buf_valid_q                 <= 1'b0;
        end else if (i_stall) begin
            if (ack_take) begin
                buf_valid_q   <= 1'b1;
                buf_rd_idx_q  <= rd_idx_q;
                buf_rd_we_q   <= rd_we_q && !we_q;
                buf_rd_data_q <= load_data;
            end
        end else if (buf_valid_q) begin
            buf_valid_q                      <= 1'b0;
            o_memory_writeback_if_valid      <= 1'b1;
            o_memory_writeback_if_rd_idx     <= buf_rd_idx_q;
            o_memory_writeback_if_rd_we      <= buf_rd_we_q;
            o_memory_writeback_if_rd_data    <= buf_rd_data_q;
            o_memory_writeback_if_misaligned <= 1'b0;
        end else if (ack_take) begin
            o_memory_writeback_if_valid      <= 1'b1;
            o_memory_writeback_if_rd_idx     <= rd_idx_q;
            o_memory_writeback_if_rd_we      <= rd_we_q && !we_q;
            o_memory_writeback_if_rd_data    <= load_data;
            o_memory_writeback_if_misaligned <= 1'b0;
        end else if (accept && !issue) begin
            o_memory_writeback_if_valid      <= 1'b1;
            o_memory_writeback_if_rd_idx     <= i_execute_memory_if_rd_idx;
            o_memory_writeback_if_rd_we      <= i_execute_memory_if_rd_we && !in_misaligned;
            o_memory_writeback_if_rd_data    <= i_execute_memory_if_alu_result;
            o_memory_writeback_if_misaligned <= in_misaligned;
        end else begin
            o_memory_writeback_if_valid <= 1'b0;
        end
    end

    // Bus outputs come straight from the captured request while a transaction is open.
    assign o_dmem_req   = (state_q != ST_IDLE);
    assign o_dmem_we    = o_dmem_req && we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_wstrb = o_dmem_req ? wstrb_q : 4'b0000;

    assign o_stall = (state_q != ST_IDLE) || i_stall || buf_valid_q || issue;

endmodule

// File: tb/tb_zacore_memory.sv
// tb/tb_zacore_memory.sv - self-checking bench for zacore_memory
module tb_zacore_memory;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] SZ_B     = 2'd0;
    localparam logic [1:0] SZ_H     = 2'd1;
    localparam logic [1:0] SZ_W     = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic [31:0] rd_data;
        logic        mis;
        logic        rd_we;
        logic        bus;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        op_t  in;
        exp_t ex;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu;
    logic [31:0] ex_sdata;
    logic [1:0]  ex_op;
    logic [1:0]  ex_size;
    logic        ex_sgn;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic        wb_rd_we;
    logic [31:0] wb_rd_data;
    logic        wb_mis;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic        stall_in;
    logic        inval;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    zacore_memory #(.ADDR_W(32), .XLEN(32)) dut (
        .i_clk                            (clk),
        .i_rst                            (rst),
        .i_execute_memory_if_valid        (ex_valid),
        .i_execute_memory_if_alu_result   (ex_alu),
        .i_execute_memory_if_store_data   (ex_sdata),
        .i_execute_memory_if_mem_op       (ex_op),
        .i_execute_memory_if_size         (ex_size),
        .i_execute_memory_if_load_signed  (ex_sgn),
        .i_execute_memory_if_rd_idx       (ex_rd),
        .i_execute_memory_if_rd_we        (ex_rd_we),
        .o_memory_writeback_if_valid      (wb_valid),
        .o_memory_writeback_if_rd_idx     (wb_rd_idx),
        .o_memory_writeback_if_rd_we      (wb_rd_we),
        .o_memory_writeback_if_rd_data    (wb_rd_data),
        .o_memory_writeback_if_misaligned (wb_mis),
        .o_dmem_req                       (dmem_req),
        .o_dmem_we                        (dmem_we),
        .o_dmem_addr                      (dmem_addr),
        .o_dmem_wdata                     (dmem_wdata),
        .o_dmem_wstrb                     (dmem_wstrb),
        .i_dmem_ack                       (dmem_ack),
        .i_dmem_rdata                     (dmem_rdata),
        .o_stall                          (stall_out),
        .i_stall                          (stall_in),
        .i_invalidate                     (inval)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0;
        ex_op    = OP_NONE;
    endtask

    task automatic drive(input op_t o);
        ex_valid = 1'b1;
        ex_op    = o.op;
        ex_size  = o.size;
        ex_sgn   = o.sgn;
        ex_alu   = o.alu;
        ex_sdata = o.sdata;
        ex_rd    = o.rd;
        ex_rd_we = o.rd_we;
    endtask

    function automatic op_t mk(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                               input logic [31:0] alu, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic rd_we, input logic [31:0] rdata);
        op_t o;
        o.op = op; o.size = size; o.sgn = sgn; o.alu = alu; o.sdata = sdata;
        o.rd = rd; o.rd_we = rd_we; o.rdata = rdata;
        return o;
    endfunction

    function automatic exp_t mke(input logic [31:0] rd_data, input logic mis, input logic rd_we,
                                 input logic bus, input logic [3:0] wstrb, input logic [31:0] wdata);
        exp_t e;
        e.rd_data = rd_data; e.mis = mis; e.rd_we = rd_we; e.bus = bus;
        e.wstrb = wstrb; e.wdata = wdata;
        return e;
    endfunction

    // Reference: byte-oriented view of an access (access width, offset, lanes).
    function automatic exp_t model(input op_t o);
        exp_t        e;
        int          off;
        int          nb;
        logic        is_mem;
        logic [3:0]  m;
        logic [31:0] v;
        off    = int'(o.alu[1:0]);
        nb     = (o.size == SZ_B) ? 1 : (o.size == SZ_H) ? 2 : 4;
        is_mem = (o.op == OP_LOAD) || (o.op == OP_STORE);
        e.mis  = is_mem && ((off % nb) != 0);
        e.bus  = is_mem && !e.mis;
        m      = 4'((1 << nb) - 1);
        e.wstrb = (o.op == OP_STORE && e.bus) ? 4'(m << off) : 4'b0000;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = o.sdata[8*(i % nb) +: 8];
        v = 32'd0;
        if (e.bus) begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = o.rdata[8*(off+i) +: 8];
            if (o.sgn && nb < 4 && v[8*nb-1]) begin
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
        end
        if (!is_mem || e.mis) begin
            e.rd_data = o.alu;
        end else if (o.op == OP_LOAD) begin
            e.rd_data = v;
        end else begin
            e.rd_data = 32'd0;
        end
        e.rd_we = (!is_mem || (o.op == OP_LOAD && !e.mis)) ? o.rd_we : 1'b0;
        return e;
    endfunction

    // One isolated instruction: accept, optional bus transaction, result check.
    task automatic do_op(input string tag, input op_t o, input exp_t e, input int ack_delay);
        drive(o);
        #1;
        check({tag, ".stall_accept"}, stall_out, e.bus);
        step();
        idle_in();
        if (e.bus) begin
            #1;
            check({tag, ".req"}, dmem_req, 1'b1);
            check({tag, ".addr"}, dmem_addr, {o.alu[31:2], 2'b00});
            check({tag, ".we"}, dmem_we, o.op == OP_STORE);
            check({tag, ".wstrb"}, dmem_wstrb, e.wstrb);
            if (o.op == OP_STORE) check({tag, ".wdata"}, dmem_wdata, e.wdata);
            for (int i = 0; i < ack_delay; i++) begin
                step();
                #1;
                check({tag, ".req_hold"}, dmem_req, 1'b1);
                check({tag, ".stall_hold"}, stall_out, 1'b1);
            end
            dmem_ack   = 1'b1;
            dmem_rdata = o.rdata;
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
        end
        #1;
        check({tag, ".valid"}, wb_valid, 1'b1);
        check({tag, ".rd_idx"}, wb_rd_idx, o.rd);
        check({tag, ".rd_we"}, wb_rd_we, e.rd_we);
        check({tag, ".rd_data"}, wb_rd_data, e.rd_data);
        check({tag, ".misaligned"}, wb_mis, e.mis);
        check({tag, ".req_done"}, dmem_req, 1'b0);
    endtask

    vec_t vecs[12];
    int   sc;

    initial begin
        rst = 1'b1; stall_in = 1'b0; inval = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        ex_alu = 32'd0; ex_sdata = 32'd0; ex_size = SZ_W; ex_sgn = 1'b0; ex_rd = 5'd0; ex_rd_we = 1'b0;
        idle_in();

        vecs[0]  = '{mk(OP_NONE,  SZ_W, 0, 32'h0000_1234, 0, 5, 1, 0),
                     mke(32'h0000_1234, 0, 1, 0, 4'h0, 32'h0)};
        vecs[1]  = '{mk(OP_LOAD,  SZ_B, 1, 32'h0000_0103, 0, 6, 1, 32'h80FF_FF7F),
                     mke(32'hFFFF_FF80, 0, 1, 1, 4'h0, 32'h0)};
        vecs[2]  = '{mk(OP_LOAD,  SZ_B, 0, 32'h0000_0103, 0, 7, 1, 32'h80FF_FF7F),
                     mke(32'h0000_0080, 0, 1, 1, 4'h0, 32'h0)};
        vecs[3]  = '{mk(OP_STORE, SZ_H, 0, 32'h0000_0202, 32'h0000_ABCD, 8, 1, 0),
                     mke(32'h0, 0, 0, 1, 4'b1100, 32'hABCD_ABCD)};
        vecs[4]  = '{mk(OP_LOAD,  SZ_W, 0, 32'h0000_0101, 0, 9, 1, 0),
                     mke(32'h0000_0101, 1, 0, 0, 4'h0, 32'h0)};
        vecs[5]  = '{mk(OP_LOAD,  SZ_H, 1, 32'h0000_0102, 0, 10, 1, 32'h8001_1234),
                     mke(32'hFFFF_8001, 0, 1, 1, 4'h0, 32'h0)};
        vecs[6]  = '{mk(OP_LOAD,  SZ_H, 0, 32'h0000_0100, 0, 11, 1, 32'h8001_F234),
                     mke(32'h0000_F234, 0, 1, 1, 4'h0, 32'h0)};
        vecs[7]  = '{mk(OP_STORE, SZ_B, 0, 32'h0000_0301, 32'h1111_115A, 12, 0, 0),
                     mke(32'h0, 0, 0, 1, 4'b0010, 32'h5A5A_5A5A)};
        vecs[8]  = '{mk(OP_STORE, SZ_W, 0, 32'h0000_0400, 32'hDEAD_BEEF, 13, 0, 0),
                     mke(32'h0, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF)};
        vecs[9]  = '{mk(OP_LOAD,  SZ_H, 1, 32'h0000_0103, 0, 14, 1, 0),
                     mke(32'h0000_0103, 1, 0, 0, 4'h0, 32'h0)};
        vecs[10] = '{mk(OP_LOAD,  SZ_W, 1, 32'h0000_0108, 0, 15, 1, 32'h1234_5678),
                     mke(32'h1234_5678, 0, 1, 1, 4'h0, 32'h0)};
        vecs[11] = '{mk(OP_STORE, SZ_W, 0, 32'h0000_0402, 32'h0BAD_F00D, 16, 1, 0),
                     mke(32'h0000_0402, 1, 0, 0, 4'h0, 32'h0)};

        step(); step();
        #1;
        check("rst.valid", wb_valid, 1'b0);
        check("rst.rd_we", wb_rd_we, 1'b0);
        check("rst.rd_data", wb_rd_data, 32'd0);
        check("rst.misaligned", wb_mis, 1'b0);
        check("rst.req", dmem_req, 1'b0);
        check("rst.we", dmem_we, 1'b0);
        check("rst.stall", stall_out, 1'b0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].in, vecs[i].ex, i % 3);

        // SH with ack three cycles after accept: stall for four cycles.
        step();
        drive(mk(OP_STORE, SZ_H, 0, 32'h0000_0202, 32'h0000_ABCD, 3, 1, 0));
        #1;
        sc = int'(stall_out);
        step();
        idle_in();
        for (int c = 1; c <= 3; c++) begin
            #1;
            sc += int'(stall_out);
            check("sh.req", dmem_req, 1'b1);
            check("sh.wdata", dmem_wdata, 32'hABCD_ABCD);
            check("sh.wstrb", dmem_wstrb, 4'b1100);
            check("sh.valid_wait", wb_valid, 1'b0);
            if (c == 3) dmem_ack = 1'b1;
            step();
            dmem_ack = 1'b0;
        end
        #1;
        check("sh.stall_cycles", sc, 4);
        check("sh.stall_after", stall_out, 1'b0);
        check("sh.valid", wb_valid, 1'b1);
        check("sh.rd_we", wb_rd_we, 1'b0);

        // Invalidate during BUS: request held to ack, result dropped.
        drive(mk(OP_LOAD, SZ_W, 0, 32'h0000_0100, 0, 4, 1, 0));
        step();
        idle_in();
        inval = 1'b1;
        #1;
        check("inv.req_c1", dmem_req, 1'b1);
        step();
        inval = 1'b0;
        #1;
        check("inv.req_c2", dmem_req, 1'b1);
        check("inv.stall_c2", stall_out, 1'b1);
        check("inv.valid_c2", wb_valid, 1'b0);
        step();
        #1;
        check("inv.req_c3", dmem_req, 1'b1);
        check("inv.stall_c3", stall_out, 1'b1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        step();
        dmem_ack = 1'b0;
        #1;
        check("inv.req_after", dmem_req, 1'b0);
        check("inv.stall_after", stall_out, 1'b0);
        check("inv.valid_after", wb_valid, 1'b0);
        step();
        #1;
        check("inv.valid_late", wb_valid, 1'b0);

        // Ack and invalidate in the same BUS cycle.
        drive(mk(OP_LOAD, SZ_W, 0, 32'h0000_0110, 0, 4, 1, 0));
        step();
        idle_in();
        inval = 1'b1;
        dmem_ack = 1'b1;
        step();
        inval = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check("ackinv.req", dmem_req, 1'b0);
        check("ackinv.stall", stall_out, 1'b0);
        check("ackinv.valid", wb_valid, 1'b0);

        // Ack while downstream stalled: result buffered, shown after stall drops.
        drive(mk(OP_LOAD, SZ_W, 0, 32'h0000_0104, 0, 9, 1, 0));
        step();
        idle_in();
        stall_in = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        check("buf.req", dmem_req, 1'b1);
        step();
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        #1;
        check("buf.valid_c2", wb_valid, 1'b0);
        check("buf.req_c2", dmem_req, 1'b0);
        step();
        #1;
        check("buf.valid_c3", wb_valid, 1'b0);
        step();
        stall_in = 1'b0;
        #1;
        check("buf.valid_c4", wb_valid, 1'b0);
        check("buf.stall_c4", stall_out, 1'b1);
        step();
        #1;
        check("buf.valid", wb_valid, 1'b1);
        check("buf.rd_idx", wb_rd_idx, 5'd9);
        check("buf.rd_data", wb_rd_data, 32'hCAFE_F00D);

        // Downstream stall blocks accept and freezes a valid output; invalidate in IDLE drops input.
        step();
        drive(mk(OP_NONE, SZ_W, 0, 32'h0000_0077, 0, 3, 1, 0));
        stall_in = 1'b1;
        #1;
        check("stl.stall", stall_out, 1'b1);
        step();
        stall_in = 1'b0;
        #1;
        check("stl.blocked", wb_valid, 1'b0);
        step();
        idle_in();
        stall_in = 1'b1;
        #1;
        check("stl.accepted", wb_valid, 1'b1);
        check("stl.data", wb_rd_data, 32'h0000_0077);
        step();
        stall_in = 1'b0;
        #1;
        check("stl.frozen_valid", wb_valid, 1'b1);
        check("stl.frozen_data", wb_rd_data, 32'h0000_0077);
        drive(mk(OP_NONE, SZ_W, 0, 32'h0000_0088, 0, 2, 1, 0));
        inval = 1'b1;
        step();
        inval = 1'b0;
        idle_in();
        #1;
        check("iinv.valid", wb_valid, 1'b0);
        step();
        #1;
        check("iinv.not_accepted", wb_valid, 1'b0);

        // Reset in BUS: request drops at once and a late ack is ignored.
        drive(mk(OP_LOAD, SZ_W, 0, 32'h0000_0200, 0, 1, 1, 0));
        step();
        idle_in();
        #1;
        check("rbus.req_before", dmem_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rbus.req", dmem_req, 1'b0);
        check("rbus.stall", stall_out, 1'b0);
        check("rbus.valid", wb_valid, 1'b0);
        check("rbus.we", dmem_we, 1'b0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        #1;
        check("rbus.late_valid", wb_valid, 1'b0);
        check("rbus.late_req", dmem_req, 1'b0);

        // Randomized isolated instructions against the reference.
        for (int n = 0; n < 60; n++) begin
            op_t o;
            o = mk(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom),
                   $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom);
            do_op($sformatf("rnd%0d", n), o, model(o), int'($urandom_range(0, 3)));
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
